// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter that shares one registered WIDTH-bit
// equality comparator among N_REQ requesters.
//
// One requester is granted, its operands are latched, the shared comparator
// runs, and a one-cycle done pulse comes back with eq and the served index.
// With continuous requests this gives one compare every two cycles.
//
// Optional feature: define CMP_STATS_EN to add the 8-bit saturating mis_cnt
// output, which counts completed compares that returned eq = 0.
module cmp_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 2,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     done,
  output logic                     eq,
  output logic [IDW-1:0]           done_id,
`ifdef CMP_STATS_EN
  output logic [7:0]               mis_cnt,
`endif
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Shared equality comparator: every bit must match.
  function automatic logic eq_fn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x == y);
  endfunction

  // Round-robin pick: first set request after position p, wrapping modulo N_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0]   w;
    logic             f;
    logic [N_REQ-1:0] rot;
    int               idx;
    w   = {IDW{1'b0}};
    f   = 1'b0;
    rot = {N_REQ{1'b0}};
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      rot = r >> idx;
      if (!f && rot[0]) begin
        f = 1'b1;
        w = IDW'(idx);
      end else begin
        f = f;
      end
    end
    return w;
  endfunction

  // Operand lane extraction for requester index w.
  function automatic logic [WIDTH-1:0] lane(input logic [N_REQ*WIDTH-1:0] v, input logic [IDW-1:0] w);
    logic [N_REQ*WIDTH-1:0] sh;
    sh = v >> (int'(w) * WIDTH);
    return sh[WIDTH-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               eq_q, eq_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win_s;
  logic               any_req_s;
  logic               cmp_eq_s;

  assign win_s     = rr_pick(req, ptr_q);
  assign any_req_s = |req;
  assign cmp_eq_s  = eq_fn(op_a_q, op_b_q);

  // Next-state and output computation for the grant/compare/respond sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = {N_REQ{1'b0}};
    done_d    = 1'b0;
    eq_d      = 1'b0;
    done_id_d = done_id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        // Both IDLE and RESP arbitrate the same way; RESP falls back to IDLE.
        if (any_req_s) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
          op_a_d  = lane(a_in, win_s);
          op_b_d  = lane(b_in, win_s);
          id_d    = win_s;
          ptr_d   = win_s;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        eq_d      = cmp_eq_s;
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= {N_REQ{1'b0}};
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      done_id_q <= {IDW{1'b0}};
      op_a_q    <= {WIDTH{1'b0}};
      op_b_q    <= {WIDTH{1'b0}};
      id_q      <= {IDW{1'b0}};
      ptr_q     <= IDW'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      done_id_q <= done_id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign eq      = eq_q;
  assign done_id = done_id_q;
  assign busy    = (state_q != ST_IDLE);

`ifdef CMP_STATS_EN
  logic [7:0] mis_cnt_q, mis_cnt_d;

  // Saturating count of done cycles that reported a mismatch.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (done_q && !eq_q && (mis_cnt_q != 8'd255)) begin
      mis_cnt_d = mis_cnt_q + 8'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Mismatch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= 8'd0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Self-checking bench for cmp_share_arb (N_REQ=4, WIDTH=2, IDW=2).
// Cycle vectors are applied one edge at a time and outputs are sampled 1 time
// unit after the rising edge. Hand-written sequences cover asynchronous reset
// in BUSY, a request pulse hidden inside BUSY, and the CMP_STATS_EN counter.
module tb_cmp_share_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] gnt;
  logic       done;
  logic       eq;
  logic [1:0] done_id;
  logic       busy;
`ifdef CMP_STATS_EN
  logic [7:0] mis_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  cmp_share_arb #(.N_REQ(4), .WIDTH(2), .IDW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .done    (done),
    .eq      (eq),
    .done_id (done_id),
`ifdef CMP_STATS_EN
    .mis_cnt (mis_cnt),
`endif
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] gnt;
    logic       done;
    logic       eq;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] g, input logic d,
                              input logic e, input logic [1:0] id, input logic bz);
    vec_t v;
    v.rst_n = r; v.req = rq; v.a = a; v.b = b;
    v.gnt = g; v.done = d; v.eq = e; v.id = id; v.busy = bz;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g, input logic d,
                         input logic e, input logic bz);
    chk({nm, " gnt"},  {28'd0, gnt}, {28'd0, g});
    chk({nm, " done"}, {31'd0, done}, {31'd0, d});
    chk({nm, " eq"},   {31'd0, eq}, {31'd0, e});
    chk({nm, " busy"}, {31'd0, busy}, {31'd0, bz});
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; a_in = 8'd0; b_in = 8'd0;

    // Seq 1: requester 0, a0=01 b0=00 -> mismatch
    add(1'b1, 4'b0001, 8'h01, 8'h00, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0001, 8'h01, 8'h00, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0000, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Seq 2: requester 2, a2=b2=10 -> match
    add(1'b1, 4'b0100, 8'h20, 8'h20, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0100, 8'h20, 8'h20, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1);
    add(1'b1, 4'b0000, 8'h20, 8'h20, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Reset so the pointer restarts at N_REQ-1
    add(1'b0, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Seq 3: all requesting, 8 grants in order 0,1,2,3,0,1,2,3
    for (int g = 0; g < 8; g++) begin
      add(1'b1, 4'b1111, 8'hE4, 8'hE4, 4'b0001 << (g % 4), 1'b0, 1'b0, 2'd0, 1'b1);
      add(1'b1, 4'b1111, 8'hE4, 8'hE4, 4'b0000, 1'b1, 1'b1, 2'(g % 4), 1'b1);
    end
    // Seq 4: after grant to 3, req=1001 -> 0 then 3 (pointer wrap)
    add(1'b1, 4'b1001, 8'hE4, 8'hE4, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b1001, 8'hE4, 8'hE4, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1);
    add(1'b1, 4'b1001, 8'hE4, 8'hE4, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b1001, 8'hE4, 8'hE4, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1);
    add(1'b1, 4'b0000, 8'hE4, 8'hE4, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Seq 5: a1=10 b1=11 (LSB differs); a1 changes to 11 after grant, no effect
    add(1'b1, 4'b0010, 8'h08, 8'h0C, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0010, 8'h0C, 8'h0C, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b1);
    add(1'b1, 4'b0000, 8'h0C, 8'h0C, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Seq 6: single requester re-granted every 2 cycles
    add(1'b1, 4'b0010, 8'h04, 8'h04, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0010, 8'h04, 8'h04, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1);
    add(1'b1, 4'b0010, 8'h04, 8'h04, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0010, 8'h04, 8'h04, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1);
    add(1'b1, 4'b0000, 8'h04, 8'h04, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Seq 7: a2=10 b2=00 (MSB differs)
    add(1'b1, 4'b0100, 8'h20, 8'h00, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 4'b0100, 8'h20, 8'h00, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1);
    add(1'b1, 4'b0000, 8'h20, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset state
    #12;
    chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset done_id", {30'd0, done_id}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; req = tbl[i].req; a_in = tbl[i].a; b_in = tbl[i].b;
      tick();
      chk_out($sformatf("v%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].eq, tbl[i].busy);
      if (tbl[i].done) begin
        chk($sformatf("v%0d done_id", i), {30'd0, done_id}, {30'd0, tbl[i].id});
      end else begin
        n_vec = n_vec;
      end
      rst_n = 1'b1;
    end

    // Reset during BUSY: pointer is 2 here, so req=0010 grants requester 1
    req = 4'b0010; a_in = 8'h00; b_in = 8'h00;
    tick();
    chk_out("rstbusy pre", 4'b0010, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("rstbusy async", 4'b0000, 1'b0, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("rstbusy nodone1", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rstbusy nodone2", 4'b0000, 1'b0, 1'b0, 1'b0);
    req = 4'b1111;
    tick();
    chk_out("rstbusy first", 4'b0001, 1'b0, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("rstbusy done", 4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("rstbusy idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Request pulse entirely inside BUSY is ignored
    req = 4'b0100;
    tick();
    chk_out("pulse gnt", 4'b0100, 1'b0, 1'b0, 1'b1);
    req = 4'b0000;
    #2 req = 4'b0001;
    #3 req = 4'b0000;
    tick();
    chk_out("pulse done", 4'b0000, 1'b1, 1'b1, 1'b1);
    chk("pulse done_id", {30'd0, done_id}, 32'd2);
    tick();
    chk_out("pulse ignored", 4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef CMP_STATS_EN
    // Saturating mismatch counter
    rst_n = 1'b0;
    #1;
    chk("stats reset", {24'd0, mis_cnt}, 32'd0);
    rst_n = 1'b1;
    req = 4'b0001; a_in = 8'h01; b_in = 8'h00;
    repeat (20) tick();
    req = 4'b0000;
    tick();
    tick();
    chk("stats 10", {24'd0, mis_cnt}, 32'd10);
    req = 4'b0001;
    repeat (580) tick();
    req = 4'b0000;
    tick();
    tick();
    chk("stats sat", {24'd0, mis_cnt}, 32'd255);
    rst_n = 1'b0;
    #1;
    chk("stats clear", {24'd0, mis_cnt}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered WIDTH-bit equality comparator among N_REQ requesters.
- Each requester presents an operand pair (a, b) with a req level.
- The block grants one requester, latches its operands, runs the shared compare and returns a one-cycle done pulse with the eq result and the served requester's index.
- It sits between the equality-check datapath and the blocks that need equality checks, so a single comparator instance serves the whole cluster.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 2, operand width in bits.
- IDW, 2, width of the requester index (must be ≥ clog2(N_REQ)).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- a_in  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  N_REQ*WIDTH  operand B, packed the same way as a_in.
- gnt  out  N_REQ  one-hot grant, a one-cycle pulse.
- done  out  1  result-valid pulse, one cycle wide.
- eq  out  1  compare result: 1 when A == B; valid only while done is high.
- done_id  out  IDW  index of the served requester; valid while done is high.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; gnt, done, eq and done_id = 0; operand registers = 0; priority pointer ptr = N_REQ-1, so requester 0 wins first.
  - An in-flight compare is dropped and no done is issued.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick winner w = first set req bit searching ptr+1, ptr+2, … with wrap-around modulo N_REQ.
  - At the edge: gnt[w] = 1, op_a = a_in[w], op_b = b_in[w], id_r = w, ptr = w, state → BUSY.
- BUSY (gnt visible this cycle, cycle C1):
  - At the edge: gnt = 0, eq = (op_a == op_b) from the shared comparator, done = 1, done_id = id_r, state → RESP.
- RESP (done visible, cycle C2):
  - At the edge: done = 0 and eq = 0.
  - If req != 0, arbitrate exactly as in IDLE (new gnt in C3, state → BUSY). Otherwise state → IDLE.
- Timing:
  - Latency from the grant edge to done is 1 cycle.
  - Peak throughput is one compare every 2 cycles; with continuous requests, gnt pulses every other cycle.
- Requester protocol:
  - Hold req high and operands stable until gnt is seen.
  - Deassert req in the cycle after gnt (C2) unless a new compare is wanted.
  - A req still high in C2 is treated as a new request, but round-robin places it last.
  - Operands are sampled only at the grant edge; later changes have no effect.
- Fairness: a requester that holds req is granted within N_REQ grants.
- Boundaries:
  - With a single requester active, that requester is re-granted every 2 cycles.
  - With all requesters active, the grant order is 0, 1, …, N_REQ-1, 0, …
  - The pointer wraps from N_REQ-1 to 0.
  - A req pulse that rises and falls entirely within BUSY is never seen and is ignored.
  - gnt and done are never high in the same cycle.
- eq is compared at the full WIDTH: all bits equal gives 1, any mismatch gives 0.

Optional Feature:
- Macro CMP_STATS_EN.
- When defined, the block adds an output port mis_cnt (8 bits):
  - Saturating count of completed compares with eq = 0.
  - Increments on each done cycle with eq = 0 and holds at 255.
  - Reset to 0.
- When undefined, the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- Reset with defaults, then req = 4'b0001, a0 = 01, b0 = 00 → gnt = 0001 in C1; in C2 done = 1, eq = 0, done_id = 0.
- req = 4'b0100, a2 = b2 = 10 → gnt = 0100; next cycle done = 1, eq = 1, done_id = 2.
- req = 4'b1111 held high for 8 grants, operands equal → grant order 0, 1, 2, 3, 0, 1, 2, 3; gnt high every 2nd cycle; 8 done pulses, all with eq = 1.
- After a grant to requester 3, req = 4'b1001 → next grant goes to 0, then to 3; the pointer wrap is confirmed.
- rst_n driven low during BUSY (gnt high) → gnt and done drop immediately; no done follows release; the first grant after release goes to requester 0.
- With CMP_STATS_EN defined: 300 mismatching compares → mis_cnt = 255; reset → mis_cnt = 0.
